// File: rtl/dlsc_raster_compare.sv
// Raster stream comparator: pairs a DUT pixel stream with an expected pixel
// stream, compares them under a bit mask, and reports mismatches with their
// raster position, a saturating error count, and frame completion.
//
// state | meaning
// RUN   | accepting paired transfers and comparing
// HALT  | stopped after a mismatch (STOP_ON_ERR), waiting for clear
// DONE  | FRAMES frames checked, waiting for clear
module dlsc_raster_compare #(
   parameter int DATA        = 8,
   parameter int CHANNELS    = 4,
   parameter int IMG_WIDTH   = 384,
   parameter int IMG_HEIGHT  = 32,
   parameter int ERR_BITS    = 16,
   parameter int FRAMES      = 1,
   parameter int STOP_ON_ERR = 0,
   localparam int W  = CHANNELS*DATA,
   localparam int XB = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
   localparam int YB = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [W-1:0]        mask,
   output logic                dut_ready,
   input  logic                dut_valid,
   input  logic [W-1:0]        dut_data,
   output logic                ref_ready,
   input  logic                ref_valid,
   input  logic [W-1:0]        ref_data,
   output logic                err_valid,
   output logic [CHANNELS-1:0] err_chan,
   output logic [XB-1:0]       err_x,
   output logic [YB-1:0]       err_y,
   output logic [ERR_BITS-1:0] err_count,
   output logic                frame_done,
   output logic [15:0]         frame_count,
   output logic                halted,
   output logic                done
);

   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic [XB-1:0]       x_q, x_d;
   logic [YB-1:0]       y_q, y_d;
   logic                err_valid_q, err_valid_d;
   logic [CHANNELS-1:0] err_chan_q, err_chan_d;
   logic [XB-1:0]       err_x_q, err_x_d;
   logic [YB-1:0]       err_y_q, err_y_d;
   logic [ERR_BITS-1:0] err_count_q, err_count_d;
   logic                frame_done_q, frame_done_d;
   logic [15:0]         frame_count_q, frame_count_d;

   logic                run;
   logic                xfer;
   logic                last_x;
   logic                last_y;
   logic [W-1:0]        diff;
   logic [CHANNELS-1:0] chan_hit;

   // Handshake and masked per-channel compare of the pixel pair on offer.
   always_comb begin
      run       = (state_q == ST_RUN);
      dut_ready = ref_valid && run && !clear;
      ref_ready = dut_valid && run && !clear;
      xfer      = dut_valid && ref_valid && run && !clear;
      last_x    = (x_q == XB'(IMG_WIDTH-1));
      last_y    = (y_q == YB'(IMG_HEIGHT-1));
      diff      = (dut_data ^ ref_data) & mask;
      chan_hit  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         chan_hit[c] = |diff[c*DATA +: DATA];
      end
   end

   // Next-state: position counters, registered compare result, counters and FSM.
   // The FSM reacts to the registered flags, so one more transfer can slip in
   // after a mismatching pixel before HALT takes hold; it is compared normally.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      err_valid_d   = 1'b0;
      err_chan_d    = err_chan_q;
      err_x_d       = err_x_q;
      err_y_d       = err_y_q;
      err_count_d   = err_count_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      if (clear) begin
         state_d       = ST_RUN;
         x_d           = '0;
         y_d           = '0;
         err_count_d   = '0;
         frame_count_d = '0;
      end else begin
         if (run) begin
            if ((STOP_ON_ERR != 0) && err_valid_q) begin
               state_d = ST_HALT;
            end else if ((FRAMES > 0) && frame_done_q &&
                         (frame_count_q == 16'(FRAMES))) begin
               state_d = ST_DONE;
            end
         end
         if (xfer) begin
            if (last_x) begin
               x_d = '0;
               y_d = last_y ? '0 : y_q + 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
            if (|chan_hit) begin
               err_valid_d = 1'b1;
               err_chan_d  = chan_hit;
               err_x_d     = x_q;
               err_y_d     = y_q;
               if (!(&err_count_q)) begin
                  err_count_d = err_count_q + 1'b1;
               end
            end
            if (last_x && last_y) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         x_q           <= '0;
         y_q           <= '0;
         err_valid_q   <= 1'b0;
         err_chan_q    <= '0;
         err_x_q       <= '0;
         err_y_q       <= '0;
         err_count_q   <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         err_valid_q   <= err_valid_d;
         err_chan_q    <= err_chan_d;
         err_x_q       <= err_x_d;
         err_y_q       <= err_y_d;
         err_count_q   <= err_count_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign err_valid   = err_valid_q;
   assign err_chan    = err_chan_q;
   assign err_x       = err_x_q;
   assign err_y       = err_y_q;
   assign err_count   = err_count_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign halted      = (state_q == ST_HALT);
   assign done        = (state_q == ST_DONE);

endmodule

// File: doc/dlsc_raster_compare.md
DLSC_RASTER_COMPARE -- requirements
Module: dlsc_raster_compare

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DATA, 8, bits per channel.
- CHANNELS, 4, parallel channels per pixel.
- IMG_WIDTH, 384, pixels per row.
- IMG_HEIGHT, 32, rows per frame.
- ERR_BITS, 16, error counter width.
- FRAMES, 1, frames to check before DONE; 0 means continuous.
- STOP_ON_ERR, 0, 1 means halt on first mismatch.
REQ-002 The block SHALL have these ports (name, direction, width, meaning); XB = clog2(IMG_WIDTH), YB = clog2(IMG_HEIGHT), W = CHANNELS*DATA:
- clk, in, 1, clock; one clock, all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- clear, in, 1, synchronous restart.
- mask, in, W, compare enable per bit; static while running.
- dut_ready, out, 1, DUT stream accept.
- dut_valid, in, 1, DUT stream valid.
- dut_data, in, W, DUT pixel.
- ref_ready, out, 1, expected stream accept.
- ref_valid, in, 1, expected stream valid.
- ref_data, in, W, expected pixel.
- err_valid, out, 1, mismatch pulse.
- err_chan, out, CHANNELS, per-channel mismatch bitmap.
- err_x, out, XB, column of mismatch.
- err_y, out, YB, row of mismatch.
- err_count, out, ERR_BITS, saturating mismatch count.
- frame_done, out, 1, last-pixel pulse.
- frame_count, out, 16, completed frames.
- halted, out, 1, state is HALT.
- done, out, 1, state is DONE.

Function
REQ-003 The state machine SHALL have states RUN, HALT and DONE; reset and clear SHALL enter RUN.
REQ-004 dut_ready SHALL equal ref_valid && state==RUN && !clear, and ref_ready SHALL equal dut_valid && state==RUN && !clear; a transfer occurs when both streams complete the handshake in the same cycle; neither stream SHALL be consumed alone.
REQ-005 Each transfer SHALL advance the position counter x; at x==IMG_WIDTH-1, x SHALL wrap to 0 and y SHALL increment; at the last pixel (IMG_WIDTH-1, IMG_HEIGHT-1), x and y SHALL both wrap to 0.
REQ-006 Compare SHALL be registered with 1-cycle latency: err_chan[c] = |((dut_data ^ ref_data) & mask) over channel c bits; err_valid = |err_chan; err_x/err_y = the transfer's position.
REQ-007 err_chan, err_x and err_y SHALL hold their last value when err_valid is low.
REQ-008 err_count SHALL increment by 1 per pixel with err_valid, not per channel, and SHALL saturate at all-ones.
REQ-009 frame_done SHALL pulse 1 cycle after the last-pixel transfer, aligned with that pixel's err_valid, and frame_count SHALL increment (wrapping) in the same cycle.
REQ-010 If FRAMES>0 and frame_count reaches FRAMES on a frame_done, state SHALL go to DONE; readies SHALL be low in DONE until clear.
REQ-011 If STOP_ON_ERR=1, the cycle err_valid is asserted state SHALL go to HALT; HALT SHALL take precedence over DONE when both conditions coincide.
REQ-012 Because of the 1-cycle compare latency, exactly one further transfer may occur after the mismatching transfer before the HALT transition takes effect; that further transfer SHALL still be compared and counted normally.
REQ-013 clear SHALL zero x, y, err_count, frame_count, err_valid and frame_done, and SHALL return state to RUN; clear SHALL win over a simultaneous transfer, which is not accepted.
REQ-014 A pending registered compare result SHALL be discarded by clear.
REQ-015 An all-zero mask SHALL never flag errors, while transfers and position counting continue.

Reset
REQ-016 On rst assertion (asynchronous), all outputs SHALL be 0 and state SHALL be RUN; readies SHALL then follow REQ-004.
REQ-017 rst asserted mid-frame SHALL discard position and counters.
REQ-018 Deassertion of rst SHALL be synchronous to clk by the integrator.

Verification
REQ-019 The bench SHALL cover these directed scenarios (WIDTH=4, HEIGHT=2, CHANNELS=2, DATA=8, FRAMES=1):
- 8 identical pixels with random valid gaps on both streams -> err_count=0, frame_done once, done=1, frame_count=1.
- Pixel (2,1) ref channel 1 differs by 0x01, mask all-ones -> err_valid once, err_chan=2'b10, err_x=2, err_y=1, err_count=1.
- Same mismatch with mask channel 1 = 0x00 -> no err_valid, err_count=0.
- STOP_ON_ERR=1, mismatch at (1,0) with both streams continuously valid -> halted=1, exactly 3 transfers total, readies low; clear -> x=0, y=0, err_count=0, RUN.
- ERR_BITS=2, FRAMES=0, every pixel mismatched over 2 frames -> err_count saturates at 3, frame_count=2.
- rst at pixel 5 then a full frame -> first compared pixel reported at (0,0), frame_count=1.
